// File: rtl/alarm_if.sv
// Alarm controller signal bundle: keypad/sensor/timebase inputs and status outputs.
interface alarm_if;
  logic       tick;
  logic       arm;
  logic       disarm;
  logic       N;
  logic       W;
  logic       D;
  logic       G;
  logic [2:0] state;
  logic       armed;
  logic       A;
  logic [4:0] count;
  logic       fault;

  // Stimulus side: drives requests and sensors, observes status.
  modport master (
    output tick, arm, disarm, N, W, D, G,
    input  state, armed, A, count, fault
  );

  // Controller side.
  modport slave (
    input  tick, arm, disarm, N, W, D, G,
    output state, armed, A, count, fault
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Intruder alarm controller: exit delay, armed watch, entry delay, timed siren
// with automatic re-arm. All outputs come straight from flops.
module alarm_ctrl #(
  parameter int EXIT_T  = 8,
  parameter int ENTRY_T = 5,
  parameter int SIREN_T = 15
) (
  input logic   clk,
  input logic   rst,
  alarm_if.slave bus
);

  localparam logic [2:0] S_DIS   = 3'd0;
  localparam logic [2:0] S_EXIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_ENTRY = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  localparam logic [4:0] EXIT_L  = 5'(EXIT_T);
  localparam logic [4:0] ENTRY_L = 5'(ENTRY_T);
  localparam logic [4:0] SIREN_L = 5'(SIREN_T);

  logic [2:0] state_q, state_d;
  logic [4:0] count_q, count_d;
  logic       fault_q, fault_d;
  logic       armed_q, armed_d;
  logic       a_q,     a_d;

  // State and output registers; reset wipes any delay in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DIS;
      count_q <= '0;
      fault_q <= 1'b0;
      armed_q <= 1'b0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fault_q <= fault_d;
      armed_q <= armed_d;
      a_q     <= a_d;
    end
  end

  // Next state and delay counter. Disarm beats arm beats sensors beats tick;
  // a delay is loaded on entry, so a coincident tick never touches it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fault_d = 1'b0;
    if (bus.disarm) begin
      state_d = S_DIS;
      count_d = '0;
    end else begin
      case (state_q)
        S_DIS: begin
          count_d = '0;
          if (bus.arm) begin
            if (bus.W && bus.D && bus.G) begin
              state_d = S_EXIT;
              count_d = EXIT_L;
            end else begin
              fault_d = 1'b1;
            end
          end
        end
        S_EXIT: begin
          if (bus.tick) begin
            if (count_q <= 5'd1) begin
              state_d = S_ARMED;
              count_d = '0;
            end else begin
              count_d = count_q - 5'd1;
            end
          end
        end
        S_ARMED: begin
          count_d = '0;
          if (!bus.W || !bus.G || (!bus.D && bus.N)) begin
            state_d = S_ALARM;
            count_d = SIREN_L;
          end else if (!bus.D) begin
            state_d = S_ENTRY;
            count_d = ENTRY_L;
          end
        end
        S_ENTRY: begin
          if (bus.tick) begin
            if (count_q <= 5'd1) begin
              state_d = S_ALARM;
              count_d = SIREN_L;
            end else begin
              count_d = count_q - 5'd1;
            end
          end
        end
        S_ALARM: begin
          if (bus.tick) begin
            if (count_q <= 5'd1) begin
              state_d = S_ARMED;
              count_d = '0;
            end else begin
              count_d = count_q - 5'd1;
            end
          end
        end
        default: begin
          // Codes 5-7 are unreachable; fall back to a safe idle.
          state_d = S_DIS;
          count_d = '0;
        end
      endcase
    end
  end

  // Status decode from the upcoming state so armed/A are registered alongside it.
  always_comb begin
    armed_d = (state_d == S_EXIT) || (state_d == S_ARMED) ||
              (state_d == S_ENTRY) || (state_d == S_ALARM);
    a_d     = (state_d == S_ALARM);
  end

  assign bus.state = state_q;
  assign bus.count = count_q;
  assign bus.fault = fault_q;
  assign bus.armed = armed_q;
  assign bus.A     = a_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: each stimulus cycle queues the hand-computed
// post-edge outputs; a monitor pops and compares one entry after every edge.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  alarm_if bus ();

  alarm_ctrl #(.EXIT_T(8), .ENTRY_T(5), .SIREN_T(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] cnt;
    logic       f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // input vector bits: [7]rst [6]tick [5]arm [4]disarm [3]N [2]W [1]D [0]G
  localparam logic [7:0] IDLE = 8'b0000_0111;
  localparam logic [7:0] TICK = 8'b0100_0111;
  localparam logic [7:0] ARM  = 8'b0010_0111;
  localparam logic [7:0] RST  = 8'b1000_0111;

  task automatic cyc(input logic [7:0] in, input logic [2:0] es,
                     input logic [4:0] ec, input logic ef);
    exp_t e;
    @(negedge clk);
    rst        = in[7];
    bus.tick   = in[6];
    bus.arm    = in[5];
    bus.disarm = in[4];
    bus.N      = in[3];
    bus.W      = in[2];
    bus.D      = in[1];
    bus.G      = in[0];
    e.st = es; e.cnt = ec; e.f = ef;
    sb.push_back(e);
  endtask

  task automatic exit_seq();
    cyc(ARM, 3'd1, 5'd8, 1'b0);
    for (int i = 1; i <= 7; i++) cyc(TICK, 3'd1, 5'(8 - i), 1'b0);
    cyc(TICK, 3'd2, 5'd0, 1'b0);
  endtask

  // Monitor: outputs settle just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic ea, eA;
      e  = sb.pop_front();
      ea = (e.st >= 3'd1) && (e.st <= 3'd4);
      eA = (e.st == 3'd4);
      checks++;
      if (bus.state !== e.st || bus.count !== e.cnt || bus.fault !== e.f ||
          bus.armed !== ea || bus.A !== eA) begin
        errors++;
        $display("FAIL chk%0d @%0t: got state=%0d count=%0d fault=%0b armed=%0b A=%0b, want state=%0d count=%0d fault=%0b armed=%0b A=%0b",
                 checks, $time, bus.state, bus.count, bus.fault, bus.armed, bus.A,
                 e.st, e.cnt, e.f, ea, eA);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.tick = 0; bus.arm = 0; bus.disarm = 0; bus.N = 0;
    bus.W = 1; bus.D = 1; bus.G = 1;

    // reset, including an arm held during reset
    cyc(RST, 3'd0, 5'd0, 1'b0);
    cyc(8'b1010_0111, 3'd0, 5'd0, 1'b0);

    // first arm accepted right after reset; exit delay ignores sensors and arm
    cyc(ARM, 3'd1, 5'd8, 1'b0);
    cyc(8'b0000_0000, 3'd1, 5'd8, 1'b0);
    cyc(ARM, 3'd1, 5'd8, 1'b0);
    for (int i = 1; i <= 7; i++) cyc(TICK, 3'd1, 5'(8 - i), 1'b0);
    cyc(TICK, 3'd2, 5'd0, 1'b0);
    cyc(IDLE, 3'd2, 5'd0, 1'b0);
    cyc(ARM, 3'd2, 5'd0, 1'b0);            // arm while armed: no fault

    // door opens -> entry delay, disarm after 3 ticks
    cyc(8'b0000_0101, 3'd3, 5'd5, 1'b0);
    cyc(8'b0100_0101, 3'd3, 5'd4, 1'b0);
    cyc(TICK, 3'd3, 5'd3, 1'b0);
    cyc(TICK, 3'd3, 5'd2, 1'b0);
    cyc(8'b0001_0111, 3'd0, 5'd0, 1'b0);

    // entry delay expires -> 15-tick siren -> auto re-arm
    exit_seq();
    cyc(8'b0100_0101, 3'd3, 5'd5, 1'b0);   // tick on entry does not decrement
    for (int i = 1; i <= 4; i++) cyc(TICK, 3'd3, 5'(5 - i), 1'b0);
    cyc(TICK, 3'd4, 5'd15, 1'b0);
    for (int i = 1; i <= 14; i++) cyc(TICK, 3'd4, 5'(15 - i), 1'b0);
    cyc(TICK, 3'd2, 5'd0, 1'b0);
    cyc(IDLE, 3'd2, 5'd0, 1'b0);

    // garage opens -> instant alarm; disarm wins over coincident tick
    cyc(8'b0000_0110, 3'd4, 5'd15, 1'b0);
    cyc(TICK, 3'd4, 5'd14, 1'b0);
    cyc(8'b0101_0111, 3'd0, 5'd0, 1'b0);

    // night mode door -> instant alarm; reset at count 9 aborts it
    exit_seq();
    cyc(8'b0000_1101, 3'd4, 5'd15, 1'b0);
    for (int i = 1; i <= 6; i++) cyc(TICK, 3'd4, 5'(15 - i), 1'b0);
    cyc(RST, 3'd0, 5'd0, 1'b0);
    cyc(8'b1010_0111, 3'd0, 5'd0, 1'b0);

    // rejected arms pulse fault for one clock; arm+disarm together is silent
    cyc(8'b0010_0011, 3'd0, 5'd0, 1'b1);
    cyc(8'b0000_0011, 3'd0, 5'd0, 1'b0);
    cyc(8'b0011_0111, 3'd0, 5'd0, 1'b0);
    cyc(8'b0010_0110, 3'd0, 5'd0, 1'b1);
    cyc(IDLE, 3'd0, 5'd0, 1'b0);

    // illegal state code recovers to DISARMED on the next edge
    @(negedge clk);
    rst = 1'b0; bus.tick = 0; bus.arm = 0; bus.disarm = 0; bus.N = 0;
    bus.W = 1; bus.D = 1; bus.G = 1;
    force dut.state_q = 3'd6;
    sb.push_back(exp_t'{st: 3'd0, cnt: 5'd0, f: 1'b0});
    #4;
    release dut.state_q;
    cyc(ARM, 3'd1, 5'd8, 1'b0);

    // let the monitor drain, then confirm nothing was left unchecked
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001: Parameter EXIT_T, default 8, exit-delay length in tick periods (1..31).
REQ-002: Parameter ENTRY_T, default 5, entry-delay length in tick periods (1..31).
REQ-003: Parameter SIREN_T, default 15, siren-on length in tick periods (1..31).
REQ-004: clk  input  1  single system clock; all state changes on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: tick  input  1  one-clk-wide timebase strobe; all delays count tick pulses only.
REQ-007: arm  input  1  one-clk arm request.
REQ-008: disarm  input  1  one-clk disarm request (valid code already checked upstream).
REQ-009: N  input  1  night/stay mode; 1 = door treated as instant zone.
REQ-010: W  input  1  window sensor; 1 = secure, 0 = open.
REQ-011: D  input  1  door sensor; 1 = secure, 0 = open.
REQ-012: G  input  1  garage sensor; 1 = secure, 0 = open.
REQ-013: state  output  3  current state encoding (per REQ-017).
REQ-014: armed  output  1  high in EXIT, ARMED, ENTRY, ALARM.
REQ-015: A  output  1  siren drive; high only in ALARM.
REQ-016: count  output  5  remaining ticks of active delay; 0 when no delay active.
REQ-024: fault  output  1  one-clk pulse when an arm request is rejected.

Function
REQ-017: FSM states: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 illegal, recover to DISARMED next clk.
REQ-018: All outputs registered; every transition and output change occurs on the clk edge after the causing input sample.
REQ-019: DISARMED + arm, W=D=G=1 -> EXIT, count loaded EXIT_T.
REQ-020: DISARMED + arm with any of W,D,G = 0 -> stay DISARMED, fault=1 for one clk.
REQ-021: EXIT: sensors ignored; each tick decrements count; tick while count==1 -> ARMED, count=0 (exactly EXIT_T ticks).
REQ-022: ARMED: W=0 or G=0 -> ALARM; D=0 with N=0 -> ENTRY, count=ENTRY_T; D=0 with N=1 -> ALARM.
REQ-023: ENTRY: sensors ignored; tick decrements count; tick while count==1 -> ALARM.
REQ-025: Entering ALARM loads count=SIREN_T; tick decrements; tick while count==1 -> ARMED, count=0, A=0 (auto re-arm; open sensors re-trigger per REQ-022 on next clk).
REQ-026: disarm in any state -> DISARMED, count=0, A=0 on next clk.
REQ-027: Priority: rst > disarm > arm > sensor events > tick.
REQ-028: arm outside DISARMED ignored, no fault.
REQ-029: tick coincident with a state entry does not decrement the freshly loaded count.
REQ-030: Count arithmetic unsigned 5-bit; never underflows below 0; no wrap.

Reset
REQ-031: rst=1 at clk edge -> state=DISARMED, armed=0, A=0, count=0, fault=0, regardless of current state.
REQ-032: rst asserted mid-delay or mid-alarm aborts the sequence; no residual count survives.
REQ-033: Outputs remain at reset values while rst held; first arm accepted on the clk after rst deasserts.

Verification
REQ-034: rst; W=D=G=1; arm pulse; 8 ticks -> state 0->1, count 8..1, ARMED after 8th tick, A=0 throughout.
REQ-035: ARMED, N=0, D=0 -> ENTRY count=5; disarm after 3 ticks -> DISARMED, A never 1.
REQ-036: ARMED, N=0, D=0, no disarm -> ALARM after 5th tick, A=1 for 15 ticks, then ARMED, A=0.
REQ-037: ARMED, G=0 (or N=1 and D=0) -> ALARM next clk, A=1, count=15.
REQ-038: DISARMED, W=0, arm -> fault pulse 1 clk, state stays 0; same clk arm+disarm -> state 0, no fault.
REQ-039: rst asserted in ALARM with count=9 -> next clk state 0, A=0, count 0; force illegal state 6 -> DISARMED next clk.
